// File: rtl/mem_out_rd_streamer_if.sv
// Bus bundle for the output-SRAM read port and the outgoing valid/ready word stream.
interface mem_out_rd_streamer_if #(
   parameter int DATA_W = 192,
   parameter int ADDR_W = 14,
   parameter int CA_W   = 4
);
   logic                     NCE;
   logic                     NWRT;
   logic [ADDR_W-CA_W-1:0]   RA;
   logic [CA_W-1:0]          CA;
   logic [DATA_W-1:0]        Q;
   logic [DATA_W-1:0]        m_data;
   logic                     m_valid;
   logic                     m_ready;
   logic                     m_last;

   modport master (
      output NCE, NWRT, RA, CA, m_data, m_valid, m_last,
      input  Q, m_ready
   );

   modport slave (
      input  NCE, NWRT, RA, CA, m_data, m_valid, m_last,
      output Q, m_ready
   );
endinterface

// File: rtl/mem_out_rd_streamer.sv
// Streams a burst of words out of the DCT output SRAM, absorbing its one-cycle read
// latency in a 2-entry FIFO so downstream backpressure never loses or repeats a word.
module mem_out_rd_streamer #(
   parameter int DATA_W = 192,
   parameter int ADDR_W = 14,
   parameter int CA_W   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      start_addr,
   input  logic [ADDR_W-1:0]      num_words_m1,
   output logic                   busy,
   output logic                   done,
   mem_out_rd_streamer_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     issue_left_q;
   logic                inflight_q;
   logic                inflight_last_q;
   logic [DATA_W-1:0]   fifo_data_q [2];
   logic [1:0]          fifo_last_q;
   logic                rd_ptr_q;
   logic                wr_ptr_q;
   logic [1:0]          count_q;
   logic                done_q;

   logic                pop;
   logic                issue;
   logic                issue_last;
   logic                head_last;
   logic [2:0]          occupancy;

   assign bus.m_valid = (count_q != 2'd0);
   assign bus.m_data  = bus.m_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign head_last   = bus.m_valid & fifo_last_q[rd_ptr_q];
   assign bus.m_last  = head_last;
   assign pop         = bus.m_valid & bus.m_ready;
   assign issue_last  = (issue_left_q == {{ADDR_W{1'b0}}, 1'b1});
   assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
   assign bus.RA      = addr_q[ADDR_W-1:CA_W];
   assign bus.CA      = addr_q[CA_W-1:0];
   assign bus.NWRT    = 1'b1;
   assign done        = done_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)              state_d = RUN;
         RUN:     if (issue && issue_last) state_d = DRAIN;
         DRAIN:   if (pop && head_last)   state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // A read is issued only if the word it returns is guaranteed a FIFO slot.
   always_comb begin
      issue = 1'b0;
      if (state_q == RUN)
         issue = ((occupancy - {2'b00, pop}) < 3'd2);
      bus.NCE = ~issue;
      busy    = (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q          <= '0;
         issue_left_q    <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_last_q     <= '0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         count_q         <= '0;
         done_q          <= 1'b0;
      end else begin
         done_q          <= pop & head_last;
         inflight_q      <= issue;
         inflight_last_q <= issue & issue_last;
         if (state_q == IDLE && start) begin
            addr_q       <= start_addr;
            issue_left_q <= {1'b0, num_words_m1} + {{ADDR_W{1'b0}}, 1'b1};
         end else if (issue) begin
            addr_q       <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            issue_left_q <= issue_left_q - {{ADDR_W{1'b0}}, 1'b1};
         end
         if (inflight_q) begin
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         unique case ({inflight_q, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; entries are only visible once count_q marks them valid.
   always_ff @(posedge clk) begin
      if (inflight_q) fifo_data_q[wr_ptr_q] <= bus.Q;
   end

endmodule

// File: tb/tb_mem_out_rd_streamer.sv
// Scoreboard bench for mem_out_rd_streamer: SRAM model with mem[k] = k replicated per coefficient.
module tb_mem_out_rd_streamer;

   localparam int DATA_W = 192;
   localparam int ADDR_W = 14;
   localparam int CA_W   = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] num_words_m1;
   logic              busy;
   logic              done;

   mem_out_rd_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CA_W(CA_W)) bus ();

   mem_out_rd_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CA_W(CA_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .start_addr   (start_addr),
      .num_words_m1 (num_words_m1),
      .busy         (busy),
      .done         (done),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [1 << ADDR_W];
   exp_t              sb [$];
   int                checks = 0;
   int                errors = 0;
   int                nce_cnt = 0;
   int                nwrt_bad = 0;
   logic              stalled = 1'b0;
   logic [DATA_W-1:0] held_data;

   function automatic logic [DATA_W-1:0] exp_word(logic [ADDR_W-1:0] a);
      return {16{a[11:0]}};
   endfunction

   task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = exp_word(ADDR_W'(k));
   end

   // SRAM with one-cycle read latency
   always @(posedge clk) begin
      if (!bus.NCE) bus.Q <= mem[{bus.RA, bus.CA}];
   end

   // Monitor: pops the scoreboard on every accepted beat, checks stall stability
   always @(negedge clk) begin
      if (reset) begin
         stalled = 1'b0;
      end else begin
         if (bus.NWRT !== 1'b1) nwrt_bad++;
         if (bus.NCE === 1'b0) nce_cnt++;
         if (stalled) begin
            check("stall_valid", DATA_W'(bus.m_valid), DATA_W'(1));
            check("stall_data", bus.m_data, held_data);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", DATA_W'(1), DATA_W'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("word_data", bus.m_data, e.data);
               check("word_last", DATA_W'(bus.m_last), DATA_W'(e.last));
            end
         end
         stalled   = bus.m_valid && !bus.m_ready;
         held_data = bus.m_data;
      end
   end

   task automatic start_burst(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n_m1);
      logic [ADDR_W-1:0] p;
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; num_words_m1 = n_m1;
      p = a;
      for (int i = 0; i <= int'(n_m1); i++) begin
         exp_t e;
         e.data = exp_word(p);
         e.last = (i == int'(n_m1));
         sb.push_back(e);
         p = p + 14'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input bit rnd_ready);
      bit found = 1'b0;
      for (int i = 0; i < max_cyc && !found; i++) begin
         if (done) found = 1'b1;
         else begin
            @(posedge clk); #1;
            if (rnd_ready) bus.m_ready = 1'($urandom_range(0, 1));
         end
      end
      check("done_seen", DATA_W'(found), DATA_W'(1));
   endtask

   task automatic check_idle_outputs(string tag);
      check({tag, "_valid"}, DATA_W'(bus.m_valid), DATA_W'(0));
      check({tag, "_last"},  DATA_W'(bus.m_last),  DATA_W'(0));
      check({tag, "_data"},  bus.m_data,           DATA_W'(0));
      check({tag, "_busy"},  DATA_W'(busy),        DATA_W'(0));
      check({tag, "_done"},  DATA_W'(done),        DATA_W'(0));
      check({tag, "_nce"},   DATA_W'(bus.NCE),     DATA_W'(1));
   endtask

   initial begin
      logic [20:0] nce_m, val_m, last_m, done_m, busy_m;
      logic [20:0] nce_e, val_e, last_e, done_e, busy_e;
      logic [ADDR_W-1:0] wrap_e [4];

      reset = 1'b1; start = 1'b0; start_addr = '0; num_words_m1 = '0; bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_idle_outputs("reset");
      check("reset_ra", DATA_W'(bus.RA), DATA_W'(0));
      check("reset_ca", DATA_W'(bus.CA), DATA_W'(0));

      // Basic 16-word burst with cycle-exact timing
      bus.m_ready = 1'b1; nce_cnt = 0;
      start_burst(14'd0, 14'd15);
      nce_m = '0; val_m = '0; last_m = '0; done_m = '0; busy_m = '0;
      for (int c = 1; c <= 20; c++) begin
         nce_m[c] = ~bus.NCE; val_m[c] = bus.m_valid; last_m[c] = bus.m_last;
         done_m[c] = done; busy_m[c] = busy;
         @(posedge clk); #1;
      end
      nce_e = '0; val_e = '0; last_e = '0; done_e = '0; busy_e = '0;
      for (int c = 1; c <= 16; c++) nce_e[c] = 1'b1;
      for (int c = 3; c <= 18; c++) val_e[c] = 1'b1;
      for (int c = 1; c <= 18; c++) busy_e[c] = 1'b1;
      last_e[18] = 1'b1; done_e[19] = 1'b1;
      check("burst16_nce_cycles",  DATA_W'(nce_m),  DATA_W'(nce_e));
      check("burst16_valid_cycles", DATA_W'(val_m), DATA_W'(val_e));
      check("burst16_last_cycles", DATA_W'(last_m), DATA_W'(last_e));
      check("burst16_done_cycles", DATA_W'(done_m), DATA_W'(done_e));
      check("burst16_busy_cycles", DATA_W'(busy_m), DATA_W'(busy_e));
      check("burst16_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

      // Address wrap across the top of memory
      nce_cnt = 0;
      wrap_e[0] = 14'h3FFE; wrap_e[1] = 14'h3FFF; wrap_e[2] = 14'h0000; wrap_e[3] = 14'h0001;
      start_burst(14'd16382, 14'd3);
      for (int c = 0; c < 4; c++) begin
         check("wrap_nce", DATA_W'(bus.NCE), DATA_W'(0));
         check("wrap_addr", DATA_W'({bus.RA, bus.CA}), DATA_W'(wrap_e[c]));
         @(posedge clk); #1;
      end
      wait_done(20, 1'b0);
      check("wrap_nce_count", DATA_W'(nce_cnt), DATA_W'(4));
      check("wrap_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

      // Random backpressure over an 8-word burst
      @(posedge clk); #1;
      nce_cnt = 0; bus.m_ready = 1'b0;
      start_burst(14'd200, 14'd7);
      wait_done(300, 1'b1);
      bus.m_ready = 1'b1;
      check("bp_nce_count", DATA_W'(nce_cnt), DATA_W'(8));
      check("bp_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

      // Single word, with start pulses during the busy burst that must be ignored
      @(posedge clk); #1;
      nce_cnt = 0;
      start_burst(14'd40, 14'd0);
      start = 1'b1; start_addr = 14'd900; num_words_m1 = 14'd5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      check("single_valid", DATA_W'(bus.m_valid), DATA_W'(1));
      check("single_last",  DATA_W'(bus.m_last),  DATA_W'(1));
      wait_done(10, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("single_busy_after", DATA_W'(busy), DATA_W'(0));
      check("single_nce_count", DATA_W'(nce_cnt), DATA_W'(1));
      check("single_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

      // Reset mid-burst with the FIFO full and downstream stalled
      bus.m_ready = 1'b0; nce_cnt = 0;
      start_burst(14'd100, 14'd7);
      repeat (6) @(posedge clk);
      #1;
      check("stall_fifo_valid", DATA_W'(bus.m_valid), DATA_W'(1));
      check("stall_nce_count", DATA_W'(nce_cnt), DATA_W'(2));
      sb.delete();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_outputs("midreset");
      @(posedge clk); #1;
      check("midreset_valid_later", DATA_W'(bus.m_valid), DATA_W'(0));
      bus.m_ready = 1'b1; nce_cnt = 0;
      start_burst(14'd500, 14'd3);
      wait_done(20, 1'b0);
      check("post_reset_nce_count", DATA_W'(nce_cnt), DATA_W'(4));
      check("post_reset_sb_empty", DATA_W'(sb.size()), DATA_W'(0));

      check("nwrt_always_high", DATA_W'(nwrt_bad), DATA_W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_out_rd_streamer.md
# mem_out_rd_streamer

Reads DCT coefficient words back out of the 16384×192 output SRAM (the memory the DCT unit writes through NWRT/NCE/RA/CA) and delivers them as a valid/ready stream. The block sits on the read side of the output memory's port, sequences row/column addresses, absorbs the SRAM's one-cycle read latency, and tolerates arbitrary downstream backpressure without dropping or duplicating words. It is the readback counterpart to the DCT-side write path.

## Interface
- DATA_W, 192: SRAM word width, 16 coefficients × 12 bits
- ADDR_W, 14: flat word address width
- CA_W, 4: column address width; RA width is ADDR_W-CA_W = 10
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  one-cycle request to begin a burst; honored only in IDLE
- start_addr  in  ADDR_W  first flat word address, sampled with start
- num_words_m1  in  ADDR_W  burst length minus 1, sampled with start (1..16384 words)
- NCE  out  1  SRAM chip enable, active-low; low only in a cycle issuing a read
- NWRT  out  1  SRAM write enable, active-low; constant 1
- RA  out  ADDR_W-CA_W  row address = addr[13:4]
- CA  out  CA_W  column address = addr[3:0]
- Q  in  DATA_W  SRAM read data
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_last  out  1  high with the final word of the burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after final word accepted

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: start=1 -> latch addr=start_addr, issue_left=num_words_m1+1 (15-bit), go RUN. start in RUN/DRAIN ignored.
- RUN: issue a read (NCE=0, RA/CA from addr) when fifo_count + inflight - pop < 2, where pop = m_valid & m_ready this cycle. Each issue: addr <= addr+1 modulo 2^14 (16383 wraps to 0), issue_left decrements. Issuing the last word -> DRAIN.
- DRAIN: no issues; when final word is popped -> done=1 next cycle, state IDLE.
- Read return: inflight flag set on an issue cycle; Q captured into the 2-entry output FIFO at the end of the following cycle. FIFO never overflows by construction; overflow is a design error.
- m_data/m_valid from FIFO head; words emitted in address order.
- m_last = m_valid & (head is the burst's final word); tracked with a per-entry last tag, not by address compare.
- busy = (state != IDLE).
- Reset at any time: state IDLE, FIFO emptied, inflight cleared, in-flight Q discarded, next cycle outputs at reset values.
- Reset values: NCE=1, NWRT=1, RA=0, CA=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.

## Timing
- Cycle 0: start sampled at edge. Cycle 1: NCE=0, address A. Cycle 2: Q=mem[A]. Cycle 3: m_valid=1, m_data=mem[A]. Start-to-first-valid = 3 cycles.
- With m_ready held 1: one word per cycle, no bubbles; N-word burst last beat in cycle N+2, done=1 in cycle N+3, busy=0 in cycle N+3.
- m_ready=0: m_valid and m_data held stable until accepted; at most 2 words buffered, issuing stops, no SRAM reads wasted.
- m_valid never depends combinationally on m_ready.
- Simultaneous start and done cycle: state already IDLE, start accepted.
- num_words_m1=16383: full memory sweep, address wraps back to start_addr, 16384 words.

## Test plan
- Preload mem[k]=k replicated; start_addr=0, num_words_m1=15, m_ready=1 -> NCE low cycles 1..16, words 0..15 in cycles 3..18, m_last only in cycle 18, done in cycle 19.
- Wrap: start_addr=16382, num_words_m1=3 -> stream mem[16382], mem[16383], mem[0], mem[1]; RA/CA wrap 0x3FF/0xF -> 0/0.
- Backpressure: 8-word burst, m_ready random 50% -> all 8 words in order exactly once, data stable while stalled, NCE low exactly 8 cycles total.
- Single word: num_words_m1=0 -> one beat with m_valid=m_last=1; start pulse during busy ignored.
- Reset mid-burst with m_ready=0 and FIFO full -> next cycle m_valid=0, busy=0, NCE=1; new start afterwards streams correctly from its own start_addr.
- NWRT observed 1 in every cycle of all tests.
